// File: rtl/riscv_uc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit:
// FSM state codes, opcode/funct fields, datapath mux/ALU encodings and
// the per-state control word.
package riscv_uc_pkg;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_LOAD_IR  = 4'd2,
    ST_DECODE   = 4'd3,
    ST_EXEC_R   = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_LD   = 4'd7,
    ST_MEM_SD   = 4'd8,
    ST_WB_ALU   = 4'd9,
    ST_WB_MEM   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_LUI      = 4'd12,
    ST_TRAP     = 4'd13
  } state_t;

  // Instruction class reported by the decoder for the DECODE transition.
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_EXEC_R  = 3'd1,
    CLS_EXEC_I  = 3'd2,
    CLS_MEM     = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_LUI     = 3'd5
  } dec_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_LDSD = 3'b011;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_IMM = 2'd2;

  localparam logic [2:0] IT_I  = 3'd0;
  localparam logic [2:0] IT_S  = 3'd1;
  localparam logic [2:0] IT_SB = 3'd2;
  localparam logic [2:0] IT_U  = 3'd3;
  localparam logic [2:0] IT_R  = 3'd4;

  // Moore control word; PCWrite is excluded because it depends on inputs.
  typedef struct packed {
    logic       load_ir;
    logic       write_reg;
    logic       load_reg_a;
    logic       load_reg_b;
    logic       load_alu_out;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] mem_to_reg;
    logic [2:0] instr_type;
    logic       illegal;
  } ctrl_t;

  // Control word asserted while the FSM sits in state st.
  function automatic ctrl_t ctrl_for_state(input state_t st,
                                           input logic   is_sub,
                                           input logic   is_store);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
      end
      ST_LOAD_IR: c.load_ir = 1'b1;
      ST_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        c.load_reg_a   = 1'b1;
        c.load_reg_b   = 1'b1;
        c.load_alu_out = 1'b1;
        c.alu_src_b    = SRCB_IMM;
        c.instr_type   = IT_SB;
      end
      ST_EXEC_R: begin
        c.load_alu_out = 1'b1;
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = SRCB_B;
        c.alu_op       = is_sub ? ALU_SUB : ALU_ADD;
        c.instr_type   = IT_R;
      end
      ST_EXEC_I: begin
        c.load_alu_out = 1'b1;
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = SRCB_IMM;
        c.alu_op       = ALU_ADD;
        c.instr_type   = IT_I;
      end
      ST_MEM_ADDR: begin
        c.load_alu_out = 1'b1;
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = SRCB_IMM;
        c.alu_op       = ALU_ADD;
        c.instr_type   = is_store ? IT_S : IT_I;
      end
      ST_MEM_LD: c.mem_read  = 1'b1;
      ST_MEM_SD: c.mem_write = 1'b1;
      ST_WB_ALU: begin
        c.write_reg  = 1'b1;
        c.mem_to_reg = M2R_ALU;
      end
      ST_WB_MEM: begin
        c.write_reg  = 1'b1;
        c.mem_to_reg = M2R_MDR;
      end
      ST_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_SUB;
      end
      ST_LUI: begin
        c.write_reg  = 1'b1;
        c.mem_to_reg = M2R_IMM;
        c.instr_type = IT_U;
      end
      ST_TRAP: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational instruction classifier: maps the instruction register to
// the FSM's post-DECODE class, plus the sub/store qualifiers the execute
// states need. Anything outside the supported subset is flagged illegal.
module uc_decode
  import riscv_uc_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_class_t  o_class,
  output logic        o_illegal,
  output logic        o_is_sub,
  output logic        o_is_store
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_fields;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  // Register and immediate fields belong to the datapath, not to control.
  assign w_unused_fields = ^{i_instr[24:15], i_instr[11:7]};

  // Classify opcode/funct3/funct7 into one of the supported instruction classes.
  always_comb begin
    o_class    = CLS_ILLEGAL;
    o_is_sub   = 1'b0;
    o_is_store = 1'b0;
    case (w_opcode)
      OP_R: begin
        if (w_funct3 == F3_ADD && w_funct7 == F7_ADD) begin
          o_class = CLS_EXEC_R;
        end else if (w_funct3 == F3_ADD && w_funct7 == F7_SUB) begin
          o_class  = CLS_EXEC_R;
          o_is_sub = 1'b1;
        end
      end
      OP_IMM:    if (w_funct3 == F3_ADD)  o_class = CLS_EXEC_I;
      OP_LOAD:   if (w_funct3 == F3_LDSD) o_class = CLS_MEM;
      OP_STORE: begin
        if (w_funct3 == F3_LDSD) begin
          o_class    = CLS_MEM;
          o_is_store = 1'b1;
        end
      end
      OP_BRANCH: if (w_funct3 == F3_BEQ || w_funct3 == F3_BNE) o_class = CLS_BRANCH;
      OP_LUI:    o_class = CLS_LUI;
      default:   o_class = CLS_ILLEGAL;
    endcase
  end

  assign o_illegal = (o_class == CLS_ILLEGAL);

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle RISC-V control unit (add/sub/addi/ld/sd/beq/bne/lui).
// Moore outputs are registered from the next state so they line up with
// Estado; PCWrite is the only input-dependent output (FETCH completion and
// branch resolution). Every memory state (FETCH, MEM_LD, MEM_SD) is bounded
// by a wait counter of MEM_TIMEOUT cycles.
// Build option: define UC_TRAP_EN to send illegal instructions and memory
// timeouts to TRAP (sticky until reset, Illegal=1); otherwise illegal
// instructions act as NOPs and a timeout restarts the access in FETCH.
//
// state    | meaning
// RST      | post-reset idle, all outputs low
// FETCH    | read instruction, PC+4 written on MemReady
// LOAD_IR  | latch instruction register
// DECODE   | load A/B, branch target into ALUOut, classify
// EXEC_R   | A op B (add/sub)
// EXEC_I   | A + imm (addi)
// MEM_ADDR | A + imm address for ld/sd
// MEM_LD   | memory read until MemReady
// MEM_SD   | memory write until MemReady
// WB_ALU   | write ALUOut to rd
// WB_MEM   | write MDR to rd
// BRANCH   | A - B, conditional PC write
// LUI      | write immediate to rd
// TRAP     | illegal/timeout, hold until reset
module uc_multiciclo
  import riscv_uc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Instr31_0,
  input  logic        MemReady,
  input  logic        AluZero,
  output logic        PCWrite,
  output logic        LoadIR,
  output logic        WriteReg,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        LoadAluOut,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        AluSrcA,
  output logic [1:0]  AluSrcB,
  output logic [2:0]  AluOp,
  output logic [1:0]  MemToReg,
  output logic [2:0]  InstrType,
  output logic        Illegal,
  output logic [3:0]  Estado
);

`ifdef UC_TRAP_EN
  localparam state_t ST_FAULT_DEST = ST_TRAP;
`else
  localparam state_t ST_FAULT_DEST = ST_FETCH;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  ctrl_t            r_ctrl;

  dec_class_t       w_dec_class;
  logic             w_dec_illegal;
  logic             w_dec_is_sub;
  logic             w_dec_is_store;

  logic             w_mem_state;
  logic             w_timeout;
  logic             w_cnt_inc;

  uc_decode u_decode (
    .i_instr    (Instr31_0),
    .o_class    (w_dec_class),
    .o_illegal  (w_dec_illegal),
    .o_is_sub   (w_dec_is_sub),
    .o_is_store (w_dec_is_store)
  );

  assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEM_LD) ||
                       (r_state == ST_MEM_SD);
  // The last allowed wait cycle still accepts MemReady; only its absence times out.
  assign w_timeout   = w_mem_state && !MemReady &&
                       (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Next-state selection; MemReady only matters in memory states.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RST:     w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (MemReady)       w_state_nxt = ST_LOAD_IR;
        else if (w_timeout) w_state_nxt = ST_FAULT_DEST;
        else                w_state_nxt = ST_FETCH;
      end
      ST_LOAD_IR: w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (w_dec_illegal) begin
          w_state_nxt = ST_FAULT_DEST;
        end else begin
          case (w_dec_class)
            CLS_EXEC_R: w_state_nxt = ST_EXEC_R;
            CLS_EXEC_I: w_state_nxt = ST_EXEC_I;
            CLS_MEM:    w_state_nxt = ST_MEM_ADDR;
            CLS_BRANCH: w_state_nxt = ST_BRANCH;
            CLS_LUI:    w_state_nxt = ST_LUI;
            default:    w_state_nxt = ST_FAULT_DEST;
          endcase
        end
      end
      ST_EXEC_R:   w_state_nxt = ST_WB_ALU;
      ST_EXEC_I:   w_state_nxt = ST_WB_ALU;
      ST_MEM_ADDR: w_state_nxt = w_dec_is_store ? ST_MEM_SD : ST_MEM_LD;
      ST_MEM_LD: begin
        if (MemReady)       w_state_nxt = ST_WB_MEM;
        else if (w_timeout) w_state_nxt = ST_FAULT_DEST;
        else                w_state_nxt = ST_MEM_LD;
      end
      ST_MEM_SD: begin
        if (MemReady)       w_state_nxt = ST_FETCH;
        else if (w_timeout) w_state_nxt = ST_FAULT_DEST;
        else                w_state_nxt = ST_MEM_SD;
      end
      ST_WB_ALU:  w_state_nxt = ST_FETCH;
      ST_WB_MEM:  w_state_nxt = ST_FETCH;
      ST_BRANCH:  w_state_nxt = ST_FETCH;
      ST_LUI:     w_state_nxt = ST_FETCH;
      ST_TRAP:    w_state_nxt = ST_TRAP;
      default:    w_state_nxt = ST_RST;
    endcase
  end

  // Counting only while waiting in the same memory state; any entry or timeout restart clears it.
  assign w_cnt_inc = w_mem_state && (w_state_nxt == r_state) && !w_timeout;

  // State, wait counter and registered Moore outputs; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_RST;
      r_wait_cnt <= '0;
      r_ctrl     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_inc ? (r_wait_cnt + CNT_W'(1)) : '0;
      r_ctrl     <= ctrl_for_state(w_state_nxt, w_dec_is_sub, w_dec_is_store);
    end
  end

  // FETCH writes PC+4 on completion; branches write the target when the compare matches funct3[0].
  assign PCWrite = ((r_state == ST_FETCH) && MemReady) ||
                   ((r_state == ST_BRANCH) && (AluZero ^ Instr31_0[12]));

  assign LoadIR     = r_ctrl.load_ir;
  assign WriteReg   = r_ctrl.write_reg;
  assign LoadRegA   = r_ctrl.load_reg_a;
  assign LoadRegB   = r_ctrl.load_reg_b;
  assign LoadAluOut = r_ctrl.load_alu_out;
  assign MemRead    = r_ctrl.mem_read;
  assign MemWrite   = r_ctrl.mem_write;
  assign AluSrcA    = r_ctrl.alu_src_a;
  assign AluSrcB    = r_ctrl.alu_src_b;
  assign AluOp      = r_ctrl.alu_op;
  assign MemToReg   = r_ctrl.mem_to_reg;
  assign InstrType  = r_ctrl.instr_type;
  assign Estado     = r_state;

`ifdef UC_TRAP_EN
  assign Illegal = r_ctrl.illegal;
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo. Main instance uses the default
// MEM_TIMEOUT; a second instance with MEM_TIMEOUT=4 covers the timeout
// boundary. Expectations follow UC_TRAP_EN when it is defined.
module tb_uc_multiciclo;

  localparam logic [3:0] E_RST = 4'd0,  E_FETCH = 4'd1, E_LOAD_IR = 4'd2, E_DECODE = 4'd3,
                         E_EXEC_R = 4'd4, E_EXEC_I = 4'd5, E_MEM_ADDR = 4'd6, E_MEM_LD = 4'd7,
                         E_MEM_SD = 4'd8, E_WB_ALU = 4'd9, E_WB_MEM = 4'd10, E_BRANCH = 4'd11,
                         E_LUI = 4'd12, E_TRAP = 4'd13;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LD   = 32'h0080B283;
  localparam logic [31:0] I_SD   = 32'h0020B823;
  localparam logic [31:0] I_BNE  = 32'h00209063;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic        clock = 1'b0;
  logic        reset, MemReady, AluZero;
  logic [31:0] Instr31_0;

  logic PCWrite, LoadIR, WriteReg, LoadRegA, LoadRegB, LoadAluOut, MemRead, MemWrite, AluSrcA, Illegal;
  logic [1:0] AluSrcB, MemToReg;
  logic [2:0] AluOp, InstrType;
  logic [3:0] Estado;

  logic t_PCWrite, t_LoadIR, t_WriteReg, t_LoadRegA, t_LoadRegB, t_LoadAluOut, t_MemRead, t_MemWrite, t_AluSrcA, t_Illegal;
  logic [1:0] t_AluSrcB, t_MemToReg;
  logic [2:0] t_AluOp, t_InstrType;
  logic [3:0] t_Estado;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  uc_multiciclo u_dut (
    .clock(clock), .reset(reset), .Instr31_0(Instr31_0), .MemReady(MemReady), .AluZero(AluZero),
    .PCWrite(PCWrite), .LoadIR(LoadIR), .WriteReg(WriteReg), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB),
    .LoadAluOut(LoadAluOut), .MemRead(MemRead), .MemWrite(MemWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
    .AluOp(AluOp), .MemToReg(MemToReg), .InstrType(InstrType), .Illegal(Illegal), .Estado(Estado)
  );

  uc_multiciclo #(.MEM_TIMEOUT(4)) u_dut_to (
    .clock(clock), .reset(reset), .Instr31_0(Instr31_0), .MemReady(MemReady), .AluZero(AluZero),
    .PCWrite(t_PCWrite), .LoadIR(t_LoadIR), .WriteReg(t_WriteReg), .LoadRegA(t_LoadRegA), .LoadRegB(t_LoadRegB),
    .LoadAluOut(t_LoadAluOut), .MemRead(t_MemRead), .MemWrite(t_MemWrite), .AluSrcA(t_AluSrcA), .AluSrcB(t_AluSrcB),
    .AluOp(t_AluOp), .MemToReg(t_MemToReg), .InstrType(t_InstrType), .Illegal(t_Illegal), .Estado(t_Estado)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then apply this cycle's inputs and let outputs settle.
  task automatic tick(input logic rdy, input logic zero);
    @(posedge clock);
    #1;
    MemReady = rdy;
    AluZero  = zero;
    #1;
  endtask

  // From FETCH (with MemReady applied) through LOAD_IR into DECODE.
  task automatic to_decode(input logic [31:0] ins);
    Instr31_0 = ins;
    tick(1'b0, 1'b0);
    check("ldir_estado", Estado, E_LOAD_IR);
    tick(1'b0, 1'b0);
    check("dec_estado", Estado, E_DECODE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_cnt;
    int rd_cnt;
    int ill_cnt;

    reset = 1'b1; MemReady = 1'b0; AluZero = 1'b0; Instr31_0 = 32'h0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("rst_estado", Estado, E_RST);
    check("rst_memread", MemRead, 1'b0);
    check("rst_pcwrite", PCWrite, 1'b0);
    check("rst_loadir", LoadIR, 1'b0);
    check("rst_illegal", Illegal, 1'b0);
    check("rst_t_estado", t_Estado, E_RST);
    reset = 1'b0;

    // add x3,x1,x2 with immediate MemReady
    Instr31_0 = I_ADD;
    wr_cnt = 0;
    tick(1'b1, 1'b0);
    check("fetch_estado", Estado, E_FETCH);
    check("fetch_memread", MemRead, 1'b1);
    check("fetch_srca", AluSrcA, 1'b0);
    check("fetch_srcb", AluSrcB, 2'd1);
    check("fetch_aluop", AluOp, 3'd0);
    check("fetch_pcwrite", PCWrite, 1'b1);
    wr_cnt += int'(WriteReg);
    tick(1'b1, 1'b0);                          // MemReady outside memory states
    check("ldir_estado", Estado, E_LOAD_IR);
    check("ldir_loadir", LoadIR, 1'b1);
    check("ldir_pcwrite", PCWrite, 1'b0);
    check("ldir_memread", MemRead, 1'b0);
    wr_cnt += int'(WriteReg);
    tick(1'b0, 1'b0);
    check("dec_estado", Estado, E_DECODE);
    check("dec_loadir", LoadIR, 1'b0);
    check("dec_rega", LoadRegA, 1'b1);
    check("dec_regb", LoadRegB, 1'b1);
    check("dec_aluout", LoadAluOut, 1'b1);
    check("dec_srcb", AluSrcB, 2'd2);
    check("dec_itype", InstrType, 3'd2);
    wr_cnt += int'(WriteReg);
    tick(1'b0, 1'b0);
    check("add_estado", Estado, E_EXEC_R);
    check("add_srca", AluSrcA, 1'b1);
    check("add_srcb", AluSrcB, 2'd0);
    check("add_aluop", AluOp, 3'd0);
    check("add_aluout", LoadAluOut, 1'b1);
    wr_cnt += int'(WriteReg);
    tick(1'b0, 1'b0);
    check("add_wb_estado", Estado, E_WB_ALU);
    check("add_wb_m2r", MemToReg, 2'd0);
    wr_cnt += int'(WriteReg);
    tick(1'b1, 1'b0);
    check("add_end_estado", Estado, E_FETCH);
    wr_cnt += int'(WriteReg);
    check("add_wr_cycles", wr_cnt, 1);

    // ld with MemReady arriving in the fifth MEM_LD cycle
    to_decode(I_LD);
    tick(1'b0, 1'b0);
    check("ld_addr_estado", Estado, E_MEM_ADDR);
    check("ld_addr_itype", InstrType, 3'd0);
    check("ld_addr_aluout", LoadAluOut, 1'b1);
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(i == 4, 1'b0);
      if (Estado == E_MEM_LD) rd_cnt += int'(MemRead);
    end
    check("ld_memread_cycles", rd_cnt, 5);
    tick(1'b0, 1'b0);
    check("ld_wb_estado", Estado, E_WB_MEM);
    check("ld_wb_write", WriteReg, 1'b1);
    check("ld_wb_m2r", MemToReg, 2'd1);
    check("ld_wb_memread", MemRead, 1'b0);
    tick(1'b1, 1'b0);
    check("ld_end_estado", Estado, E_FETCH);

    // sub
    to_decode(I_SUB);
    tick(1'b0, 1'b0);
    check("sub_estado", Estado, E_EXEC_R);
    check("sub_aluop", AluOp, 3'd1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);

    // addi
    to_decode(I_ADDI);
    tick(1'b0, 1'b0);
    check("addi_estado", Estado, E_EXEC_I);
    check("addi_srcb", AluSrcB, 2'd2);
    check("addi_aluop", AluOp, 3'd0);
    tick(1'b0, 1'b0);
    check("addi_wb_estado", Estado, E_WB_ALU);
    tick(1'b1, 1'b0);

    // lui
    to_decode(I_LUI);
    tick(1'b0, 1'b0);
    check("lui_estado", Estado, E_LUI);
    check("lui_write", WriteReg, 1'b1);
    check("lui_m2r", MemToReg, 2'd2);
    check("lui_itype", InstrType, 3'd3);
    tick(1'b1, 1'b0);
    check("lui_end_estado", Estado, E_FETCH);

    // bne, AluZero=0 -> taken
    to_decode(I_BNE);
    tick(1'b0, 1'b0);
    check("bne_estado", Estado, E_BRANCH);
    check("bne_aluop", AluOp, 3'd1);
    check("bne_pcwrite", PCWrite, 1'b1);
    tick(1'b1, 1'b0);

    // beq, AluZero=0 -> not taken, AluZero=1 -> taken
    to_decode(I_BEQ);
    tick(1'b0, 1'b0);
    check("beq_nz_pcwrite", PCWrite, 1'b0);
    AluZero = 1'b1;
    #1;
    check("beq_z_pcwrite", PCWrite, 1'b1);
    tick(1'b1, 1'b0);
    check("beq_end_estado", Estado, E_FETCH);

    // illegal opcode 0x7F
    to_decode(I_BAD);
    tick(1'b1, 1'b0);
`ifdef UC_TRAP_EN
    check("ill_estado", Estado, E_TRAP);
    ill_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      ill_cnt += int'(Illegal);
    end
    check("ill_held_cycles", ill_cnt, 10);
    check("ill_trap_memread", MemRead, 1'b0);
    check("ill_trap_estado", Estado, E_TRAP);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    check("ill_rst_estado", Estado, E_RST);
    check("ill_rst_illegal", Illegal, 1'b0);
    reset = 1'b0;
    tick(1'b1, 1'b0);
`else
    ill_cnt = 0;
    check("ill_estado", Estado, E_FETCH);
    check("ill_illegal", Illegal, ill_cnt[0]);
`endif
    check("ill_end_estado", Estado, E_FETCH);

    // sd interrupted by reset in MEM_SD
    to_decode(I_SD);
    tick(1'b0, 1'b0);
    check("sd_addr_estado", Estado, E_MEM_ADDR);
    check("sd_addr_itype", InstrType, 3'd1);
    tick(1'b0, 1'b0);
    check("sd_estado", Estado, E_MEM_SD);
    check("sd_memwrite", MemWrite, 1'b1);
    check("sd_memread", MemRead, 1'b0);
    tick(1'b0, 1'b0);
    check("sd_hold_estado", Estado, E_MEM_SD);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    check("sd_rst_estado", Estado, E_RST);
    check("sd_rst_memwrite", MemWrite, 1'b0);
    reset = 1'b0;

    // MEM_TIMEOUT=4: MemReady in the fourth FETCH cycle is still a success
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    tick(1'b0, 1'b0);
    check("to_ok_c1", t_Estado, E_FETCH);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("to_ok_c4_estado", t_Estado, E_FETCH);
    check("to_ok_c4_pcwrite", t_PCWrite, 1'b1);
    tick(1'b0, 1'b0);
    check("to_ok_loadir", t_Estado, E_LOAD_IR);

    // MEM_TIMEOUT=4: MemReady never asserted
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    check("to_c4_estado", t_Estado, E_FETCH);
    tick(1'b0, 1'b0);
`ifdef UC_TRAP_EN
    check("to_trap_estado", t_Estado, E_TRAP);
    check("to_trap_illegal", t_Illegal, 1'b1);
    check("to_trap_memread", t_MemRead, 1'b0);
`else
    check("to_restart_estado", t_Estado, E_FETCH);
    check("to_restart_memread", t_MemRead, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("to_restart_c4_pcwrite", t_PCWrite, 1'b1);
    tick(1'b0, 1'b0);
    check("to_restart_loadir", t_Estado, E_LOAD_IR);
    check("to_restart_illegal", t_Illegal, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
